// File: rtl/operand_vector_packer_if.sv
// Handshake bundle between the operand stream producer, the packer and the adder-tree front layer.
interface operand_vector_packer_if #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8
);
  localparam int CW = $clog2(INPUTS_AMOUNT) + 1;

  logic [P-1:0]  in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          in_last_i;
  logic          in_signed_i;
  logic [P-1:0]  out_data_o [INPUTS_AMOUNT];
  logic          out_signed_o;
  logic [CW-1:0] out_count_o;
  logic          out_valid_o;
  logic          out_ready_i;

  modport master (
    output in_data_i, in_valid_i, in_last_i, in_signed_i, out_ready_i,
    input  in_ready_o, out_data_o, out_signed_o, out_count_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, in_signed_i, out_ready_i,
    output in_ready_o, out_data_o, out_signed_o, out_count_o, out_valid_o
  );
endinterface

// File: rtl/operand_vector_packer.sv
// Packs a serial P-bit operand stream into an INPUTS_AMOUNT-slot vector for the adder tree.
// Optional OPERAND_PACKER_B2B_EN lets the first beat of the next vector land during the output handshake.
module operand_vector_packer_slot #(
  parameter int P = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we,
  input  logic         clr,
  input  logic [P-1:0] d,
  output logic [P-1:0] q
);
  // A write wins over the clear so a back-to-back beat survives into slot 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  q <= '0;
    else if (we)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module operand_vector_packer #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  operand_vector_packer_if.slave bus
);
  localparam int IW = $clog2(INPUTS_AMOUNT);
  localparam int CW = IW + 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                             state;
  logic [IW-1:0]                      idx;
  logic [IW-1:0]                      wr_idx;
  logic                               accept;
  logic                               consume;
  logic                               closing;
  logic                               sgn_q;
  logic [CW-1:0]                      cnt_q;
  logic [INPUTS_AMOUNT-1:0]           we;
  logic [INPUTS_AMOUNT-1:0][P-1:0]    slot_q;

  always_comb begin
`ifdef OPERAND_PACKER_B2B_EN
    bus.in_ready_o = (state == FILL) || bus.out_ready_i;
`else
    bus.in_ready_o = (state == FILL);
`endif
  end

  assign accept  = bus.in_valid_i && bus.in_ready_o;
  assign consume = (state == FULL) && bus.out_ready_i;
  // A beat accepted while FULL can only be the first beat of the next vector.
  assign wr_idx  = (state == FULL) ? '0 : idx;
  assign closing = bus.in_last_i || (wr_idx == IW'(INPUTS_AMOUNT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FILL;
      idx   <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (consume) begin
        state <= FILL;
        idx   <= '0;
        cnt_q <= '0;
      end
      if (accept) begin
        if (wr_idx == '0) sgn_q <= bus.in_signed_i;
        if (closing) begin
          state <= FULL;
          idx   <= '0;
          cnt_q <= {1'b0, wr_idx} + CW'(1);
        end else begin
          idx   <= wr_idx + IW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < INPUTS_AMOUNT; k++) begin : g_slot
    assign we[k] = accept && (wr_idx == IW'(k));
    operand_vector_packer_slot #(.P(P)) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we     (we[k]),
      .clr    (consume),
      .d      (bus.in_data_i),
      .q      (slot_q[k])
    );
    assign bus.out_data_o[k] = slot_q[k];
  end

  assign bus.out_valid_o  = (state == FULL);
  assign bus.out_signed_o = sgn_q;
  assign bus.out_count_o  = cnt_q;
endmodule

// File: tb/tb_operand_vector_packer.sv
// Bench for operand_vector_packer: vector table, corner sequences, then random traffic vs a queue model.
module tb_operand_vector_packer;
  localparam int N = 8;
  localparam int P = 8;
`ifdef OPERAND_PACKER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_vector_packer_if #(.INPUTS_AMOUNT(N), .P(P)) bus ();

  operand_vector_packer #(.INPUTS_AMOUNT(N), .P(P)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the vector under construction / on display is just a queue of beats.
  bit         m_full;
  logic [7:0] m_vec[$];
  logic       m_sgn;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [63:0] act_data();
    logic [63:0] v = '0;
    for (int k = 0; k < N; k++) v[k*8 +: 8] = bus.out_data_o[k];
    return v;
  endfunction

  function automatic logic [63:0] exp_data();
    logic [63:0] v = '0;
    for (int k = 0; k < N; k++) if (k < m_vec.size()) v[k*8 +: 8] = m_vec[k];
    return v;
  endfunction

  task automatic check_all();
    chk("out_valid",  64'(bus.out_valid_o),  64'(m_full));
    chk("out_count",  64'(bus.out_count_o),  m_full ? 64'(m_vec.size()) : 64'd0);
    chk("out_signed", 64'(bus.out_signed_o), 64'(m_sgn));
    chk("out_data",   act_data(),            exp_data());
  endtask

  task automatic model_update(input bit acc, input logic [7:0] d, input logic l,
                              input logic s, input bit cons);
    if (cons) begin
      m_full = 1'b0;
      m_vec.delete();
    end
    if (acc) begin
      if (m_vec.size() == 0) m_sgn = s;
      m_vec.push_back(d);
      if (l || m_vec.size() == N) m_full = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, check ready, update model on the rising edge, check outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic s,
                      input logic r, output bit acc);
    bit er;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.in_last_i   = l;
    bus.in_signed_i = s;
    bus.out_ready_i = r;
    #1;
    er = !m_full || (B2B && r);
    chk("in_ready", 64'(bus.in_ready_o), 64'(er));
    acc = v && bus.in_ready_o;
    @(posedge clk);
    model_update(v && er, d, l, s, m_full && r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.in_last_i   = 1'b0;
    bus.in_signed_i = 1'b0;
    bus.out_ready_i = 1'b0;
    rst_n = 1'b0;
    #2;
    m_full = 1'b0;
    m_vec.delete();
    m_sgn = 1'b0;
    check_all();
    chk("rst_ready", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct packed {
    int              n;
    int              last_at;
    logic            sgn;
    logic [7:0][7:0] d;
    int              exp_cnt;
    logic            exp_sgn;
    logic [7:0][7:0] exp_slot;
  } vec_t;

  vec_t tv[4];

  initial begin
    bit         acc;
    int         cyc;
    int         nacc;
    logic [7:0] nxt;
    logic [63:0] snap;
    logic       rdy_hist[64];

    tv[0].n = 8; tv[0].last_at = -1; tv[0].sgn = 1'b0;
    tv[0].d        = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    tv[0].exp_cnt  = 8; tv[0].exp_sgn = 1'b0;
    tv[0].exp_slot = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    tv[1].n = 3; tv[1].last_at = 2; tv[1].sgn = 1'b1;
    tv[1].d        = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h80, 8'hFF};
    tv[1].exp_cnt  = 3; tv[1].exp_sgn = 1'b1;
    tv[1].exp_slot = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h80, 8'hFF};
    tv[2].n = 1; tv[2].last_at = 0; tv[2].sgn = 1'b0;
    tv[2].d        = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
    tv[2].exp_cnt  = 1; tv[2].exp_sgn = 1'b0;
    tv[2].exp_slot = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
    tv[3].n = 8; tv[3].last_at = 7; tv[3].sgn = 1'b1;
    tv[3].d        = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    tv[3].exp_cnt  = 8; tv[3].exp_sgn = 1'b1;
    tv[3].exp_slot = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};

    do_reset();

    // Table vectors; later beats carry the opposite sign to show it is ignored.
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < tv[t].n; b++)
        step(1'b1, tv[t].d[b], 1'(b == tv[t].last_at), (b == 0) ? tv[t].sgn : ~tv[t].sgn, 1'b1, acc);
      chk("tbl_valid",  64'(bus.out_valid_o),  64'd1);
      chk("tbl_count",  64'(bus.out_count_o),  64'(tv[t].exp_cnt));
      chk("tbl_signed", 64'(bus.out_signed_o), 64'(tv[t].exp_sgn));
      for (int k = 0; k < N; k++)
        chk("tbl_slot", 64'(bus.out_data_o[k]), 64'(tv[t].exp_slot[k]));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      chk("tbl_consumed", 64'(bus.out_valid_o), 64'd0);
    end

    // Backpressure: vector held for 5 cycles while the producer keeps offering.
    for (int b = 0; b < N; b++) step(1'b1, 8'(8'h31 + b), 1'b0, 1'b0, 1'b0, acc);
    snap = act_data();
    chk("bp_snap", snap, 64'h3837363534333231);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
      chk("bp_ready", 64'(acc), 64'd0);
      chk("bp_hold",  act_data(), snap);
      chk("bp_count", 64'(bus.out_count_o), 64'd8);
      chk("bp_valid", 64'(bus.out_valid_o), 64'd1);
    end
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, acc);
    chk("bp_handshake", 64'(bus.out_valid_o), 64'd0);
    do_reset();

    // Two full vectors with valid held high.
    nxt = 8'd1; nacc = 0; cyc = 0;
    while (nacc < 16 && cyc < 40) begin
      step(1'b1, nxt, 1'b0, 1'b0, 1'b1, acc);
      rdy_hist[cyc] = acc;
      cyc++;
      if (acc) begin
        nacc++;
        nxt++;
      end
    end
    chk("b2b_cycles", 64'(cyc), B2B ? 64'd16 : 64'd17);
    if (!B2B) chk("b2b_bubble", 64'(rdy_hist[8]), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Reset mid-fill, then a clean full vector.
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, acc);
    do_reset();
    for (int b = 0; b < N; b++) step(1'b1, 8'(8'h21 + b), 1'b0, 1'b0, 1'b0, acc);
    chk("rst_clean_data",   act_data(), 64'h2827262524232221);
    chk("rst_clean_count",  64'(bus.out_count_o),  64'd8);
    chk("rst_clean_signed", 64'(bus.out_signed_o), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Random traffic against the queue model.
    for (int c = 0; c < 1500; c++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
